tis100_output_collector: RTL and testbench

- Downstream consumer of the TIS100 grid's bottom-row output ports. Arbitrates word writes from up to four output columns using the node-side write handshake.
- Tags each accepted word with its column and buffers it in a FIFO.
- Presents the buffer head on the host read interface: outData / dataFrom / dataReady / read.
- Backpressures the grid when the buffer is full: a column that is not accepted simply hangs, which matches TIS100 port semantics.

---
 rtl/tis100_pkg.sv | 23 ++
 rtl/tis100_sync_fifo.sv | 53 +++++
 rtl/tis100_output_collector.sv | 96 +++++++++
 tb/tb_tis100_output_collector.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tis100_pkg.sv
// Shared widths, node-type characters and the buffered entry layout for the
// TIS100 output collector.
package tis100_pkg;

  localparam int WORD_W   = 11;
  localparam int NUM_COLS = 4;
  localparam int COL_W    = 2;

  // ASCII tags used by the grid description to name node types
  localparam logic [7:0] NODE_COMPUTE = 8'h43;  // 'C'
  localparam logic [7:0] NODE_STACK   = 8'h53;  // 'S'
  localparam logic [7:0] NODE_DAMAGED = 8'h44;  // 'D'
  localparam logic [7:0] NODE_INPUT   = 8'h49;  // 'I'
  localparam logic [7:0] NODE_OUTPUT  = 8'h4F;  // 'O'

  typedef struct packed {
    logic [COL_W-1:0]  col;
    logic [WORD_W-1:0] word;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/tis100_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head is visible on dout
// whenever the FIFO is non-empty and reads as zero when it is empty.
module tis100_sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 16,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; empty forces the head to zero
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tis100_output_collector.sv
// Collects words from the grid's bottom-row output columns with round-robin
// arbitration, tags each with its column and buffers it for the host.
// A column that is not granted simply keeps waiting, which is how a TIS100
// port blocks.
module tis100_output_collector
  import tis100_pkg::*;
#(
  parameter int                  DEPTH  = 16,
  parameter logic [NUM_COLS-1:0] COL_EN = 4'b0010
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_COLS*WORD_W-1:0] colData,
  input  logic [NUM_COLS-1:0]        colValid,
  output logic [NUM_COLS-1:0]        colDone,
  input  logic                       read,
  output logic [WORD_W-1:0]          outData,
  output logic [COL_W-1:0]           dataFrom,
  output logic                       dataReady,
  output logic [$clog2(DEPTH):0]     count
);

  logic [NUM_COLS-1:0] eligible;
  logic [COL_W-1:0]    rr;
  logic [COL_W-1:0]    idx;
  logic [COL_W-1:0]    grant_col;
  logic                grant;
  logic [WORD_W-1:0]   word_sel;
  logic                fifo_full;
  logic                fifo_empty;
  entry_t              push_entry;
  entry_t              head;

  // A column in its done cycle is masked so its held word is not taken twice
  assign eligible = colValid & COL_EN & ~colDone;

  // Round-robin search starting at rr; nothing is granted while full
  always_comb begin
    grant     = 1'b0;
    grant_col = '0;
    idx       = '0;
    for (int k = 0; k < NUM_COLS; k++) begin
      idx = rr + COL_W'(k);
      if (!grant && eligible[idx]) begin
        grant     = 1'b1;
        grant_col = idx;
      end
    end
    if (fifo_full) grant = 1'b0;
  end

  // Select the granted column's word from the packed data bus
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (grant_col == COL_W'(i)) word_sel = colData[i*WORD_W +: WORD_W];
    end
  end

  assign push_entry.col  = grant_col;
  assign push_entry.word = word_sel;

  // Registered one-hot done strobe and rotating priority pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr      <= '0;
      colDone <= '0;
    end else begin
      colDone <= '0;
      if (grant) begin
        colDone[grant_col] <= 1'b1;
        rr                 <= grant_col + 1'b1;
      end
    end
  end

  tis100_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .pop   (read),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign dataReady = !fifo_empty;
  assign outData   = head.word;
  assign dataFrom  = head.col;

endmodule

// File: tb/tb_tis100_output_collector.sv
// Scoreboard bench for the output collector. Three instances cover the
// default configuration (a), all columns enabled (b) and a shallow buffer (c).
module tb_tis100_output_collector;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [43:0] cd_a, cd_b, cd_c;
  logic [3:0]  cv_a, cv_b, cv_c;
  logic [3:0]  done_a, done_b, done_c;
  logic        rd_a, rd_b, rd_c;
  logic [10:0] out_a, out_b, out_c;
  logic [1:0]  from_a, from_b, from_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic [4:0]  cnt_a, cnt_b;
  logic [2:0]  cnt_c;

  logic [12:0] exp_a[$];
  logic [12:0] exp_b[$];
  logic [12:0] exp_c[$];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tis100_output_collector #(.DEPTH(16), .COL_EN(4'b0010)) u_a (
    .clk(clk), .rst(rst_n), .colData(cd_a), .colValid(cv_a), .colDone(done_a),
    .read(rd_a), .outData(out_a), .dataFrom(from_a), .dataReady(rdy_a), .count(cnt_a));

  tis100_output_collector #(.DEPTH(16), .COL_EN(4'b1111)) u_b (
    .clk(clk), .rst(rst_n), .colData(cd_b), .colValid(cv_b), .colDone(done_b),
    .read(rd_b), .outData(out_b), .dataFrom(from_b), .dataReady(rdy_b), .count(cnt_b));

  tis100_output_collector #(.DEPTH(4), .COL_EN(4'b0100)) u_c (
    .clk(clk), .rst(rst_n), .colData(cd_c), .colValid(cv_c), .colDone(done_c),
    .read(rd_c), .outData(out_c), .dataFrom(from_c), .dataReady(rdy_c), .count(cnt_c));

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] done_of(input int inst);
    case (inst)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic int qsize(input int inst);
    case (inst)
      0:       return exp_a.size();
      1:       return exp_b.size();
      default: return exp_c.size();
    endcase
  endfunction

  task automatic set_col(input int inst, input int col, input logic [10:0] w, input logic v);
    case (inst)
      0:       begin cd_a[col*11 +: 11] = w; cv_a[col] = v; end
      1:       begin cd_b[col*11 +: 11] = w; cv_b[col] = v; end
      default: begin cd_c[col*11 +: 11] = w; cv_c[col] = v; end
    endcase
  endtask

  task automatic set_rd(input int inst, input logic v);
    case (inst)
      0:       rd_a = v;
      1:       rd_b = v;
      default: rd_c = v;
    endcase
  endtask

  // Node model: hold the word until done, drop valid on the edge ending done
  task automatic send(input int inst, input int col, input logic [10:0] w);
    bit         seen = 1'b0;
    logic [3:0] d;
    set_col(inst, col, w, 1'b1);
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      d = done_of(inst);
      if (d[col]) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: inst %0d col %0d got no done, required done", inst, col);
    end else begin
      check("done_onehot", $countones(d), 1);
    end
    @(posedge clk); #1;
    set_col(inst, col, w, 1'b0);
  endtask

  task automatic drain(input int inst);
    bit ok = 1'b0;
    set_rd(inst, 1'b1);
    for (int t = 0; t < 60 && !ok; t++) begin
      @(posedge clk); #1;
      if (qsize(inst) == 0) ok = 1'b1;
    end
    set_rd(inst, 1'b0);
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: inst %0d left %0d entries, required 0", inst, qsize(inst));
    end
  endtask

  task automatic pop_check(input int inst, input logic [12:0] act);
    logic [12:0] e;
    if (qsize(inst) == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_pop: inst %0d got %0h, required no data", inst, act);
    end else begin
      case (inst)
        0:       e = exp_a.pop_front();
        1:       e = exp_b.pop_front();
        default: e = exp_c.pop_front();
      endcase
      check($sformatf("head_inst%0d", inst), int'(act), int'(e));
    end
  endtask

  // Monitors: compare the head against the scoreboard on every accepted read
  always @(negedge clk) if (rst_n && rd_a && rdy_a) pop_check(0, {from_a, out_a});
  always @(negedge clk) if (rst_n && rd_b && rdy_b) pop_check(1, {from_b, out_b});
  always @(negedge clk) if (rst_n && rd_c && rdy_c) pop_check(2, {from_c, out_c});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cd_a = '0; cd_b = '0; cd_c = '0;
    cv_a = '0; cv_b = '0; cv_c = '0;
    rd_a = 1'b0; rd_b = 1'b0; rd_c = 1'b0;
    #3;
    check("rst_rdy", rdy_a, 0);
    check("rst_cnt", cnt_a, 0);
    check("rst_out", out_a, 0);
    check("rst_done", done_a, 0);
    #20;
    @(posedge clk); #1 rst_n = 1'b1;

    // Idle with read pulsed: nothing may appear
    for (int i = 0; i < 4; i++) begin
      rd_a = i[0];
      @(negedge clk);
      check("idle_rdy", rdy_a, 0);
      check("idle_cnt", cnt_a, 0);
      check("idle_out", out_a, 0);
      check("idle_done", done_a, 0);
      @(posedge clk); #1;
    end
    rd_a = 1'b0;

    // Column 1 writes 999
    exp_a.push_back({2'd1, 11'h3E7});
    send(0, 1, 11'h3E7);
    @(negedge clk);
    check("single_done_low", done_a, 0);
    check("single_rdy", rdy_a, 1);
    check("single_out", out_a, 11'h3E7);
    check("single_from", from_a, 1);
    check("single_cnt", cnt_a, 1);
    @(posedge clk); #1 rd_a = 1'b1;
    @(posedge clk); #1 rd_a = 1'b0;
    @(negedge clk);
    check("single_popped_rdy", rdy_a, 0);
    check("single_popped_out", out_a, 0);
    check("single_popped_cnt", cnt_a, 0);

    // Disabled column 3 is never served
    @(posedge clk); #1 set_col(0, 3, 11'd123, 1'b1);
    repeat (8) begin
      @(negedge clk);
      check("disabled_done", done_a, 0);
    end
    check("disabled_rdy", rdy_a, 0);
    check("disabled_cnt", cnt_a, 0);
    @(posedge clk); #1 set_col(0, 3, 11'd123, 1'b0);

    // All four columns at once; column 0 follows up with 42
    exp_b.push_back({2'd0, 11'h7FB});
    exp_b.push_back({2'd1, 11'h007});
    exp_b.push_back({2'd2, 11'h064});
    exp_b.push_back({2'd3, 11'h419});
    exp_b.push_back({2'd0, 11'h02A});
    fork
      begin send(1, 0, 11'h7FB); send(1, 0, 11'h02A); end
      send(1, 1, 11'h007);
      send(1, 2, 11'h064);
      send(1, 3, 11'h419);
    join
    @(negedge clk);
    check("rr_cnt", cnt_b, 5);
    @(posedge clk); #1;
    drain(1);

    // Shallow buffer fills and backpressures column 2
    for (int w = 1; w <= 6; w++) exp_c.push_back({2'd2, 11'(w)});
    fork
      for (int w = 1; w <= 6; w++) send(2, 2, 11'(w));
      begin
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("full_cnt", cnt_c, 4);
        check("full_done", done_c, 0);
        check("full_valid_held", cv_c[2], 1);
        @(posedge clk); #1 rd_c = 1'b1;
        @(posedge clk); #1 rd_c = 1'b0;
        @(negedge clk);
        check("full_read_cnt", cnt_c, 3);
        check("full_read_no_push", done_c, 0);
        @(negedge clk);
        check("full_refill_done", done_c, 4'b0100);
        check("full_refill_cnt", cnt_c, 4);
        @(posedge clk); #1;
        drain(2);
      end
    join

    // Push 10 then 20 with a read alongside the second push
    @(posedge clk); #1;
    exp_a.push_back({2'd1, 11'd10});
    exp_a.push_back({2'd1, 11'd20});
    send(0, 1, 11'd10);
    set_col(0, 1, 11'd20, 1'b1);
    rd_a = 1'b1;
    @(posedge clk); #1 rd_a = 1'b0;
    @(negedge clk);
    check("pp_cnt", cnt_a, 1);
    check("pp_out", out_a, 20);
    check("pp_from", from_a, 1);
    check("pp_done", done_a, 4'b0010);

    // Asynchronous reset with column 1 still offering a word
    @(posedge clk); #1;
    set_col(0, 1, 11'd30, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_rdy", rdy_a, 0);
    check("arst_cnt", cnt_a, 0);
    check("arst_out", out_a, 0);
    check("arst_from", from_a, 0);
    exp_a.delete();
    repeat (2) begin
      @(negedge clk);
      check("arst_done", done_a, 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    exp_a.push_back({2'd1, 11'd30});
    send(0, 1, 11'd30);
    drain(0);

    check("scoreboard_empty", exp_a.size() + exp_b.size() + exp_c.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
